// File: rtl/mmc1_cpu_write_filter_if.sv
// CPU-side bus and write-strobe outputs of the MMC1 write filter.
// DROP_CNT exists only when MMC1_WR_DEBUG_EN is defined.
interface mmc1_cpu_write_filter_if;
    logic       nCPU_ROMSEL;
    logic       nCPU_RW;
    logic       CPU_A14;
    logic       CPU_A13;
    logic       CPU_D0;
    logic       CPU_D7;
    logic       WR_STB;
    logic       WR_RESET;
    logic       WR_BIT;
    logic [1:0] WR_SEL;
    logic       READY;
`ifdef MMC1_WR_DEBUG_EN
    logic [7:0] DROP_CNT;
`endif

    modport master (
        output nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
        input  WR_STB, WR_RESET, WR_BIT, WR_SEL, READY
`ifdef MMC1_WR_DEBUG_EN
        , input DROP_CNT
`endif
    );

    modport slave (
        input  nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0, CPU_D7,
        output WR_STB, WR_RESET, WR_BIT, WR_SEL, READY
`ifdef MMC1_WR_DEBUG_EN
        , output DROP_CNT
`endif
    );
endinterface

// File: rtl/mmc1_cpu_write_filter.sv
// MMC1 CPU write qualifier: power-on settle, consecutive-write rejection, one-cycle strobes.
// Optional MMC1_WR_DEBUG_EN adds a saturating dropped-write counter (DROP_CNT).
module mmc1_cpu_write_filter #(
    parameter int POR_CYCLES     = 8,
    parameter int HOLDOFF_CYCLES = 1,
    parameter int CNT_W          = 4
) (
    input  logic                       CPU_M2,
    input  logic                       nRESET,
    mmc1_cpu_write_filter_if.slave     bus
);

    typedef enum logic [1:0] {SETTLE, IDLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] POR_LOAD  = CNT_W'(POR_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam state_t RESET_STATE = (POR_CYCLES == 0) ? IDLE : SETTLE;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             wc;
    logic             accept;
    logic             stb_next, rst_next, ready_next;
    logic             stb_q, rst_q, bit_q, ready_q;
    logic [1:0]       sel_q;

    assign wc = !bus.nCPU_ROMSEL && !bus.nCPU_RW;

    // State register; everything advances on the falling edge of M2.
    always_ff @(negedge CPU_M2 or negedge nRESET) begin
        if (!nRESET) begin
            state   <= RESET_STATE;
            cnt     <= POR_LOAD;
            stb_q   <= 1'b0;
            rst_q   <= 1'b0;
            bit_q   <= 1'b0;
            sel_q   <= 2'b00;
            ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= state_next;
            cnt     <= cnt_next;
            stb_q   <= stb_next;
            rst_q   <= rst_next;
            ready_q <= ready_next;
            if (accept) begin
                bit_q <= bus.CPU_D0;
                sel_q <= {bus.CPU_A14, bus.CPU_A13};
            end
        end
    end

    // Next-state logic. A write seen in HOLD restarts the holdoff window.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_next = state;
        cnt_next   = cnt;
        case (state)
            SETTLE: begin
                if (cnt <= CNT_ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            IDLE: begin
                if (wc) begin
                    cnt_next   = HOLD_LOAD;
                    state_next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (wc) begin
                    cnt_next = HOLD_LOAD;
                end else if (cnt <= CNT_ONE) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: values the output registers take on this edge.
    always_comb begin
        accept     = (state == IDLE) && wc;
        stb_next   = accept && !bus.CPU_D7;
        rst_next   = accept &&  bus.CPU_D7;
        ready_next = ready_q || (state_next != SETTLE);
    end

    assign bus.WR_STB   = stb_q;
    assign bus.WR_RESET = rst_q;
    assign bus.WR_BIT   = bit_q;
    assign bus.WR_SEL   = sel_q;
    assign bus.READY    = ready_q;

`ifdef MMC1_WR_DEBUG_EN
    logic [7:0] drop_cnt;
    logic       drop;

    assign drop = wc && (state != IDLE);

    always_ff @(negedge CPU_M2 or negedge nRESET) begin
        if (!nRESET) begin
            drop_cnt <= 8'h00;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

    assign bus.DROP_CNT = drop_cnt;
`endif

endmodule
